// File: rtl/fifo4_port_ctrl.sv
// fifo4_port_ctrl: shares FIFO4 between writers A/B and one reader; FIFO4_PORT_CTRL_RR_EN selects round-robin (else A wins).
// Each op is 3 cycles (decide, strobe, recover); writes stall while full, reads while empty, flush empties FIFO4.
module fifo4_port_ctrl (
  input  logic       clk,
  input  logic       clr,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [3:0] din_a,
  input  logic [3:0] din_b,
  output logic       gnt_a,
  output logic       gnt_b,
  input  logic       rd_req,
  output logic [3:0] rd_data,
  output logic       rd_valid,
  input  logic       flush,
  output logic [3:0] fifo_din,
  output logic       fifo_write,
  output logic       fifo_read,
  output logic       fifo_clr,
  input  logic [3:0] fifo_dout,
  input  logic       fifo_empty,
  input  logic       fifo_full
);
  typedef enum logic [2:0] {IDLE, WR, WR_REC, RD, RD_REC, FLUSH} state_t;

  state_t     state, state_nxt;
  logic       last_wr, last_wr_nxt;
  logic       sel_b, sel_b_nxt;
  logic [3:0] din_nxt;
  logic       wr_elig, rd_elig, go_wr, pick_b;

  assign wr_elig = (req_a | req_b) & ~fifo_full;
  assign rd_elig = rd_req & ~fifo_empty;
  // with both sides eligible, take the opposite of the last completed op
  assign go_wr   = wr_elig & (~rd_elig | ~last_wr);

`ifdef FIFO4_PORT_CTRL_RR_EN
  logic rr_b;
  assign pick_b = req_b & (~req_a | rr_b);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      rr_b <= 1'b0;
    else if (state == WR)
      rr_b <= ~sel_b;
  end
`else
  assign pick_b = req_b & ~req_a;
`endif

  always_comb begin
    state_nxt   = state;
    last_wr_nxt = last_wr;
    sel_b_nxt   = sel_b;
    din_nxt     = fifo_din;
    case (state)
      IDLE: begin
        if (go_wr) begin
          state_nxt = WR;
          sel_b_nxt = pick_b;
          din_nxt   = pick_b ? din_b : din_a;
        end else if (rd_elig) begin
          state_nxt = RD;
        end
      end
      WR: begin
        state_nxt   = WR_REC;
        last_wr_nxt = 1'b1;
      end
      RD: begin
        state_nxt   = RD_REC;
        last_wr_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
    // flush overrides any decision, including a pending requester latch
    if (flush) begin
      state_nxt = FLUSH;
      sel_b_nxt = sel_b;
      din_nxt   = fifo_din;
    end

    fifo_write = (state == WR);
    gnt_a      = (state == WR) & ~sel_b;
    gnt_b      = (state == WR) & sel_b;
    fifo_read  = (state == RD);
    rd_valid   = (state == RD_REC);
    fifo_clr   = clr | (state == FLUSH);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      last_wr  <= 1'b0;
      sel_b    <= 1'b0;
      fifo_din <= 4'd0;
      rd_data  <= 4'd0;
    end else begin
      state    <= state_nxt;
      last_wr  <= last_wr_nxt;
      sel_b    <= sel_b_nxt;
      fifo_din <= din_nxt;
      if (state == RD && !flush)
        rd_data <= fifo_dout;
    end
  end
endmodule

// File: tb/tb_fifo4_port_ctrl.sv
// Bench for fifo4_port_ctrl: behavioural FIFO4, vector table, directed corner sequences, random scoreboard run.
module tb_fifo4_port_ctrl;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, rd_req = 1'b0, flush = 1'b0;
  logic [3:0] din_a = 4'd0, din_b = 4'd0;
  logic       gnt_a, gnt_b, rd_valid, fifo_write, fifo_read, fifo_clr;
  logic [3:0] rd_data, fifo_din, fifo_dout;
  logic       fifo_empty, fifo_full;

`ifdef FIFO4_PORT_CTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  fifo4_port_ctrl dut (
    .clk(clk), .clr(clr), .req_a(req_a), .req_b(req_b), .din_a(din_a), .din_b(din_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .flush(flush), .fifo_din(fifo_din), .fifo_write(fifo_write), .fifo_read(fifo_read),
    .fifo_clr(fifo_clr), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  // first-word-fall-through FIFO4 stand-in
  logic [3:0] fm [4];
  int         fcnt;
  always @(posedge clk or posedge fifo_clr) begin
    if (fifo_clr) fcnt <= 0;
    else if (fifo_write && fcnt < 4) begin
      fm[fcnt[1:0]] <= fifo_din;
      fcnt <= fcnt + 1;
    end else if (fifo_read && fcnt > 0) begin
      fm[0] <= fm[1];
      fm[1] <= fm[2];
      fm[2] <= fm[3];
      fcnt  <= fcnt - 1;
    end
  end
  assign fifo_empty = (fcnt == 0);
  assign fifo_full  = (fcnt == 4);
  assign fifo_dout  = fm[0];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // {gnt_a, gnt_b, fifo_write, fifo_read, fifo_din, rd_valid, rd_data, fifo_clr}
  function automatic logic [13:0] obs();
    return {gnt_a, gnt_b, fifo_write, fifo_read, fifo_din, rd_valid, rd_data, fifo_clr};
  endfunction

  // inp = {req_a, req_b, din_a, din_b, rd_req, flush}; exp sampled one edge later
  typedef struct {
    logic [11:0] inp;
    logic [13:0] exp;
  } vec_t;
  vec_t vt [18];

  task automatic do_reset();
    req_a = 1'b0; req_b = 1'b0; rd_req = 1'b0; flush = 1'b0; clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic write_word(input bit b, input logic [3:0] d);
    bit got;
    got = 1'b0;
    if (b) begin req_b = 1'b1; din_b = d; end
    else   begin req_a = 1'b1; din_a = d; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = b ? gnt_b : gnt_a;
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("write_grant", 32'(got), 32'd1);
  endtask

  bit         got, gb, last_b, pw;
  int         n;
  logic [3:0] gd, pdin, sbv;
  bit         gq [$];
  int         vc [$];
  logic [3:0] vd [$];
  logic [3:0] sbq [$];

  initial begin
    vt[0]  = '{12'b1_0_1010_0000_0_0, 14'b1_0_1_0_1010_0_0000_0};
    vt[1]  = '{12'b0_0_1010_0000_0_0, 14'b0_0_0_0_1010_0_0000_0};
    vt[2]  = '{12'b0_0_1010_0000_0_0, 14'b0_0_0_0_1010_0_0000_0};
    vt[3]  = '{12'b0_0_1010_0000_1_0, 14'b0_0_0_1_1010_0_0000_0};
    vt[4]  = '{12'b0_0_1010_0000_0_0, 14'b0_0_0_0_1010_1_1010_0};
    vt[5]  = '{12'b0_0_1010_0000_0_0, 14'b0_0_0_0_1010_0_1010_0};
    vt[6]  = '{12'b0_1_1010_0101_0_0, 14'b0_1_1_0_0101_0_1010_0};
    vt[7]  = '{12'b0_0_1010_0101_0_0, 14'b0_0_0_0_0101_0_1010_0};
    vt[8]  = '{12'b0_0_1010_0101_0_0, 14'b0_0_0_0_0101_0_1010_0};
    vt[9]  = '{12'b0_0_1010_0101_0_1, 14'b0_0_0_0_0101_0_1010_1};
    vt[10] = '{12'b0_0_1010_0101_0_0, 14'b0_0_0_0_0101_0_1010_0};
    vt[11] = '{12'b0_0_1010_0101_1_0, 14'b0_0_0_0_0101_0_1010_0};
    vt[12] = '{12'b0_0_1010_0101_1_0, 14'b0_0_0_0_0101_0_1010_0};
    vt[13] = '{12'b1_1_0011_1100_0_0, 14'b1_0_1_0_0011_0_1010_0};
    vt[14] = '{12'b0_1_0011_1100_0_0, 14'b0_0_0_0_0011_0_1010_0};
    vt[15] = '{12'b0_1_0011_1100_0_0, 14'b0_0_0_0_0011_0_1010_0};
    vt[16] = '{12'b0_1_0011_1100_0_0, 14'b0_1_1_0_1100_0_1010_0};
    vt[17] = '{12'b0_0_0011_1100_0_0, 14'b0_0_0_0_1100_0_1010_0};

    @(negedge clk);
    chk("reset_outputs", 32'(obs()), 32'(14'b0_0_0_0_0000_0_0000_1));
    do_reset();

    for (int i = 0; i < 18; i++) begin
      {req_a, req_b, din_a, din_b, rd_req, flush} = vt[i].inp;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(vt[i].exp));
    end

    // both requesters held: grant order, then full stops further writes
    do_reset();
    req_a = 1'b1; din_a = 4'd1; req_b = 1'b1; din_b = 4'd2;
    repeat (30) begin
      @(negedge clk);
      if (gnt_a) gq.push_back(1'b0);
      if (gnt_b) gq.push_back(1'b1);
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("both_grant_count", 32'(gq.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("both_grant%0d", k), (k < gq.size()) ? 32'(gq[k]) : 32'd9, RR ? 32'(k % 2) : 32'd0);
      chk($sformatf("both_word%0d", k), 32'(fm[k]), (RR && (k % 2 == 1)) ? 32'd2 : 32'd1);
    end
    chk("both_full", 32'(fifo_full), 32'd1);

    // drain 3,5,9 with rd_req held
    do_reset();
    write_word(1'b0, 4'd3); write_word(1'b0, 4'd5); write_word(1'b0, 4'd9);
    rd_req = 1'b1; n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rd_valid) begin vc.push_back(c); vd.push_back(rd_data); end
      if (fifo_read) n++;
    end
    rd_req = 1'b0;
    chk("drain_valid_count", 32'(vc.size()), 32'd3);
    chk("drain_read_count", 32'(n), 32'd3);
    chk("drain_data0", (vd.size() > 0) ? 32'(vd[0]) : 32'hff, 32'd3);
    chk("drain_data1", (vd.size() > 1) ? 32'(vd[1]) : 32'hff, 32'd5);
    chk("drain_data2", (vd.size() > 2) ? 32'(vd[2]) : 32'hff, 32'd9);
    chk("drain_gap01", (vc.size() > 1) ? 32'(vc[1] - vc[0]) : 32'hff, 32'd3);
    chk("drain_gap12", (vc.size() > 2) ? 32'(vc[2] - vc[1]) : 32'hff, 32'd3);

    // write/read alternation starting from last op = read, one word stored
    do_reset();
    write_word(1'b0, 4'd1); write_word(1'b0, 4'd2);
    rd_req = 1'b1; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = rd_valid;
    end
    rd_req = 1'b0;
    chk("alt_setup_read", 32'(got), 32'd1);
    gq.delete();
    req_a = 1'b1; din_a = 4'd7; rd_req = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (fifo_write) gq.push_back(1'b0);
      if (fifo_read)  gq.push_back(1'b1);
    end
    req_a = 1'b0; rd_req = 1'b0;
    for (int k = 0; k < 4; k++)
      chk($sformatf("alt_op%0d", k), (k < gq.size()) ? 32'(gq[k]) : 32'd9, 32'(k % 2));

    // flush landing in the WR cycle
    do_reset();
    req_a = 1'b1; din_a = 4'd6; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = gnt_a;
    end
    chk("flush_grant_issued", 32'(got), 32'd1);
    flush = 1'b1; req_a = 1'b0;
    @(negedge clk);
    chk("flush_cycle", 32'({fifo_clr, fifo_write, fifo_read}), 32'b100);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_empty", 32'(fifo_empty), 32'd1);
    rd_req = 1'b1; n = 0;
    repeat (8) begin
      @(negedge clk);
      n += int'(fifo_read | rd_valid);
    end
    rd_req = 1'b0;
    chk("flush_no_read", 32'(n), 32'd0);

    // asynchronous clr during RD
    do_reset();
    write_word(1'b0, 4'he);
    rd_req = 1'b1; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = fifo_read;
    end
    chk("clr_rd_reached", 32'(got), 32'd1);
    #1 clr = 1'b1;
    #1 chk("clr_async", 32'({fifo_read, fifo_clr}), 32'b01);
    @(negedge clk);
    clr = 1'b0; rd_req = 1'b0; n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(rd_valid);
    end
    chk("clr_no_valid", 32'(n), 32'd0);
    write_word(1'b1, 4'd3);
    @(negedge clk);
    chk("clr_restart", 32'({fifo_empty, fm[0]}), 32'({1'b0, 4'd3}));

    // random traffic against an ordered-word scoreboard
    do_reset();
    last_b = 1'b1; pw = 1'b0; pdin = 4'd0; sbq.delete();
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      chk("rnd_proto", 32'({fifo_write ^ (gnt_a | gnt_b), pw & fifo_write, pw & (fifo_din != pdin)}), 32'd0);
      if (gnt_a || gnt_b) begin
        gb = gnt_b;
        gd = gb ? din_b : din_a;
        chk("rnd_grant", 32'({gnt_a & gnt_b, gb ? req_b : req_a, fifo_din}), 32'({1'b0, 1'b1, gd}));
        if (req_a && req_b)
          chk("rnd_arb", 32'(gb), RR ? 32'(~last_b) : 32'd0);
        chk("rnd_room", 32'(sbq.size() < 4), 32'd1);
        sbq.push_back(gd);
        last_b = gb;
      end
      if (fifo_read)
        chk("rnd_rd_nonempty", 32'(sbq.size() > 0), 32'd1);
      if (rd_valid) begin
        sbv = (sbq.size() > 0) ? sbq.pop_front() : 4'hx;
        chk("rnd_rdata", 32'(rd_data), 32'(sbv));
      end
      if (fifo_clr) sbq.delete();
      pw = fifo_write; pdin = fifo_din;

      if (gnt_a) req_a = 1'b0;
      else if (!req_a && $urandom_range(3) == 0) begin req_a = 1'b1; din_a = 4'($urandom()); end
      if (gnt_b) req_b = 1'b0;
      else if (!req_b && $urandom_range(3) == 0) begin req_b = 1'b1; din_b = 4'($urandom()); end
      rd_req = ($urandom_range(2) != 0);
      flush  = ($urandom_range(60) == 0);
    end
    req_a = 1'b0; req_b = 1'b0; rd_req = 1'b0; flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo4_port_ctrl.md
# fifo4_port_ctrl

Clocked sequencer that shares the 4-bit, 4-deep FIFO4 buffer between two write requesters (A, B) and one reader. It sits in front of FIFO4 and is the only block that drives its `din`, `write`, `read` and `clr` pins. It decides which requester writes, shapes the write and read strobes as one-cycle pulses with stable data around them, and blocks writes when the FIFO is full and reads when it is empty. Sampled read data is returned to the reader with a valid pulse.

## Interface
- No parameters. Data width is fixed at 4 and depth is owned by FIFO4.
- `clk`  in  1  system clock; everything is registered on its rising edge.
- `clr`  in  1  reset, asynchronous and active-high. Also forces `fifo_clr` high combinationally.
- `req_a`, `req_b`  in  1  write request. Hold high with data stable until the matching grant pulse.
- `din_a`, `din_b`  in  4  write data for each requester.
- `gnt_a`, `gnt_b`  out  1  one-cycle pulse when that requester's word is written.
- `rd_req`  in  1  reader wants one word. Level-sensitive; each read operation consumes one word.
- `rd_data`  out  4  registered read word.
- `rd_valid`  out  1  one-cycle pulse; `rd_data` is valid while it is high.
- `flush`  in  1  synchronous request to empty the FIFO.
- `fifo_din`  out  4  drives FIFO4 `din`.
- `fifo_write`, `fifo_read`  out  1  drive FIFO4 `write` and `read`.
- `fifo_clr`  out  1  drives FIFO4 `clr`. Equals `clr | flush_pulse`.
- `fifo_dout`  in  4  from FIFO4 `dout`.
- `fifo_empty`, `fifo_full`  in  1  from FIFO4.

## Operation
- States: IDLE, WR, WR_REC, RD, RD_REC, FLUSH.
- Reset values: state = IDLE, all outputs 0 except `fifo_clr` = 1, `last_op` = READ, `rr_ptr` = A.
- Eligibility is sampled only in IDLE:
  - write eligible = `(req_a | req_b) & !fifo_full`
  - read eligible = `rd_req & !fifo_empty`
- IDLE transitions:
  - If only write is eligible: go to WR.
  - If only read is eligible: go to RD.
  - If both are eligible: go to RD when `last_op` = WRITE, otherwise go to WR. This alternation prevents starvation of either side.
- Requester selection happens on the IDLE→WR transition:
  - Only one requester requesting: that requester wins.
  - Both requesting: the arbitration rule (see Configuration) decides.
  - The selected `din_x` is latched into `fifo_din`.
- WR: `fifo_write` = 1, `gnt_x` = 1 for the selected requester, `last_op` ← WRITE. Next state is WR_REC.
- WR_REC: `fifo_write` = 0 and `fifo_din` is held unchanged. Next state is IDLE.
- RD: `fifo_read` = 1, `last_op` ← READ. On the exit edge, `rd_data` ← `fifo_dout`. Next state is RD_REC.
- RD_REC: `fifo_read` = 0, `rd_valid` = 1. Next state is IDLE.
- `flush` sampled high in any state: next state is FLUSH.
  - FLUSH drives `fifo_clr` = 1 for one cycle, with `fifo_write` = `fifo_read` = 0, then returns to IDLE.
  - If the flush lands during WR or WR_REC, the grant already issued stands and the word is discarded.
  - An aborted RD produces no `rd_valid`.
  - `flush` takes priority over any IDLE decision.
- `fifo_din` holds its last value outside WR and WR_REC; it is never driven to X.
- A request that drops before its grant is ignored at the next IDLE evaluation.

## Timing
- Write: IDLE decision at edge n. `fifo_write` and `gnt` are high in cycle n+1, low in n+2, and the block is back in IDLE at n+3. Sustained throughput is one write per 3 cycles.
- Read: RD in cycle n+1, `rd_valid` with `rd_data` in cycle n+2, IDLE at n+3.
- `fifo_din` is stable from the start of WR through the end of WR_REC. That is one full cycle of setup before and after the falling edge of `fifo_write`.
- Asserting `clr` mid-operation aborts immediately: outputs go to their reset values asynchronously. After `clr` is released, the first decision is taken at the first rising edge.
- `fifo_full` / `fifo_empty` changes during an operation have no effect until the next IDLE.

## Configuration
- Macro: `FIFO4_PORT_CTRL_RR_EN`.
- Defined: round-robin arbitration. `rr_ptr` names the preferred requester, starts at A, and toggles to the other requester after each grant.
- Undefined: fixed priority, A always beats B, and `rr_ptr` is not implemented.
- All other behaviour is identical in both builds.

## Test plan
- Reset release, `req_a` = 1 with `din_a` = 4'b1010, FIFO empty → `gnt_a` pulse 1 cycle after IDLE. `fifo_write` is a 1-cycle pulse and `fifo_din` = 1010 for 2 cycles. `fifo_empty` then drops.
- `req_a` and `req_b` held high continuously, 4 writes:
  - with `RR_EN`: grants go A, B, A, B.
  - without `RR_EN`: grants go A, A, A, A.
  - After the 4th write `fifo_full` = 1 and no further `fifo_write` pulse occurs.
- FIFO holding 3, 5, 9 and `rd_req` held → `rd_valid` pulses every 3 cycles with `rd_data` = 3, 5, 9. No read is issued once `fifo_empty` = 1.
- `req_a` and `rd_req` both high, FIFO holding 1 word with `last_op` = READ → sequence is WR then RD, alternating while both stay eligible.
- `flush` asserted in the WR cycle → `gnt` pulse already issued, FLUSH cycle shows `fifo_clr` = 1, FIFO becomes empty, and a following `rd_req` is not serviced.
- `clr` pulsed during RD → `fifo_read` = 0 and `fifo_clr` = 1 immediately, no `rd_valid`, and the block restarts in IDLE.
